// File: rtl/uart_tx_fifo_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_cfg
//   Parametrised UART transmitter with an input FIFO. Words enter through a
//   valid/ready handshake, are queued in a small FIFO and leave on TX_OUT as
//   start / data (LSB first) / optional parity / one or two stop bits. Each
//   bit lasts PRESCALE clock cycles (0 behaves as 1). Frame configuration is
//   captured when a word is popped, so a frame is never disturbed by config
//   changes made while it is on the line. Queued words follow each other
//   with no idle bit in between.
//
// Ports
//   CLK         in   system clock, all logic on the rising edge
//   RST         in   asynchronous reset, active low
//   P_DATA      in   word to transmit, LSB first
//   Data_Valid  in   P_DATA valid this cycle
//   Data_Ready  out  FIFO can accept a word (not full)
//   PAR_EN      in   1: insert a parity bit
//   PAR_TYP     in   0: even parity, 1: odd parity
//   STOP_2      in   1: two stop bits, 0: one
//   PRESCALE    in   clock cycles per bit, 0 treated as 1
//   TX_OUT      out  serial line, idle high, registered
//   busy        out  frame in progress, registered
//   ovf         out  one-cycle pulse: a write was dropped because full
// ---------------------------------------------------------------------------
module uart_tx_fifo_cfg #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    output logic                      Data_Ready,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP_2,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      ovf
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned BW   = $clog2(DATA_WIDTH);
    localparam int unsigned CNTW = PRESCALE_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      ovf_q, ovf_d;

    state_e                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
    logic                      par_bit_q, par_bit_d;
    logic                      par_en_q, par_en_d;
    logic                      stop2_q, stop2_d;
    logic [PRESCALE_WIDTH-1:0] div_q, div_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                      full;
    logic                      empty;
    logic                      wr_en;
    logic                      pop;
    logic [DATA_WIDTH-1:0]     head;
    logic [PRESCALE_WIDTH-1:0] div_eff;
    logic [CNTW-1:0]           bit_len;
    logic                      bit_done;

    // Ready comes from the registered count only, so a write that arrives
    // while full is dropped even if a pop happens in the same cycle.
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign wr_en      = Data_Valid && !full;
    assign head       = mem_q[rd_ptr_q];
    assign div_eff    = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;

    // The second stop bit is folded into a single STOP state of 2*DIV cycles.
    assign bit_len    = (state_q == S_STOP && stop2_q) ? {div_q, 1'b0}
                                                       : {1'b0, div_q};
    assign bit_done   = (cnt_q == bit_len - CNTW'(1));

    assign Data_Ready = !full;
    assign TX_OUT     = tx_q;
    assign busy       = busy_q;
    assign ovf        = ovf_q;

    // ------------------------------------------------------------------
    // FIFO storage (contents need no reset; emptiness is held by count)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= P_DATA;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and count
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = Data_Valid && full;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit FSM: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        pop       = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNTW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (!empty) begin
                    pop = 1'b1;
                end
            end

            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    tx_d      = shreg_q[0];
                    bit_cnt_d = '0;
                end
            end

            S_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Bit 0 of the register is on the line; present the
                        // next one while shifting it into place.
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end

            S_STOP: begin
                if (bit_done) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A pop from IDLE or from the last stop cycle starts a new frame and
        // captures the configuration it will use.
        if (pop) begin
            state_d   = S_START;
            shreg_d   = head;
            par_bit_d = PAR_TYP ? ~^head : ^head;
            par_en_d  = PAR_EN;
            stop2_d   = STOP_2;
            div_d     = div_eff;
            cnt_d     = '0;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= PRESCALE_WIDTH'(1);
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule
